// File: rtl/qbert_poller_pkg.sv
// Shared definitions for the Qbert switch poller: FSM states, default
// parameter values and the counter-width helper.
package qbert_poller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } poll_state_t;

  localparam int DEF_DATA_WIDTH   = 4;
  localparam int DEF_POLL_PERIOD  = 50000;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_SLAVE_ADDR   = 0;
  localparam int DEF_STABLE_COUNT = 3;

  // Bits needed for a counter that never exceeds n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qbert_switch_debounce.sv
// Debounce filter: a sample must repeat STABLE_COUNT times in a row before
// it replaces the presented switch word; edges are reported as 1-cycle pulses.
module qbert_switch_debounce
  import qbert_poller_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] sw_value,
  output logic [DATA_WIDTH-1:0] sw_rise,
  output logic [DATA_WIDTH-1:0] sw_fall,
  output logic                  sw_changed
);

  localparam int SW = cnt_width(STABLE_COUNT + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_COUNT);

  logic [DATA_WIDTH-1:0] cand_reg, cand_next;
  logic [SW-1:0]         stable_reg, stable_next;
  logic                  update;

  // Candidate tracking: count repeats of the same sample, restart on a new one.
  always_comb begin
    cand_next   = cand_reg;
    stable_next = stable_reg;
    if (sample_valid) begin
      if (sample == cand_reg) begin
        if (stable_reg != STABLE_MAX) stable_next = stable_reg + 1'b1;
      end else begin
        cand_next   = sample;
        stable_next = SW'(1);
      end
    end
  end

  assign update = sample_valid && (stable_next == STABLE_MAX) && (cand_next != sw_value);

  // Debounce state and output word/pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_reg   <= '0;
      stable_reg <= '0;
      sw_value   <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      cand_reg   <= cand_next;
      stable_reg <= stable_next;
      sw_changed <= update;
      sw_rise    <= update ? (cand_next & ~sw_value) : '0;
      sw_fall    <= update ? (~cand_next & sw_value) : '0;
      if (update) sw_value <= cand_next;
    end
  end

endmodule

// File: rtl/qbert_switch_poller.sv
// Avalon-MM read master that polls the switch PIO every POLL_PERIOD cycles
// and feeds the sampled word through the debounce filter.
module qbert_switch_poller
  import qbert_poller_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int POLL_PERIOD  = DEF_POLL_PERIOD,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int SLAVE_ADDR   = DEF_SLAVE_ADDR,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] sw_value,
  output logic [DATA_WIDTH-1:0] sw_rise,
  output logic [DATA_WIDTH-1:0] sw_fall,
  output logic                  sw_changed
);

  localparam int PW = cnt_width(POLL_PERIOD);
  localparam int LW = cnt_width(READ_LATENCY + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LATENCY - 1);

  poll_state_t           state_reg, state_next;
  logic [PW-1:0]         poll_reg, poll_next;
  logic [LW-1:0]         lat_reg, lat_next;
  logic [DATA_WIDTH-1:0] sample_reg, sample_next;

  assign avm_address = 2'(SLAVE_ADDR);

  // Only the switch bits of the read word matter; the rest are dropped.
  generate
    if (DATA_WIDTH < 32) begin : g_unused_hi
      logic unused_readdata_hi;
      assign unused_readdata_hi = ^avm_readdata[31:DATA_WIDTH];
    end
  endgenerate

  // State, poll timer, latency counter and captured read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      poll_reg   <= '0;
      lat_reg    <= '0;
      sample_reg <= '0;
    end else begin
      state_reg  <= state_next;
      poll_reg   <= poll_next;
      lat_reg    <= lat_next;
      sample_reg <= sample_next;
    end
  end

  // Next-state logic; once a read is issued it always runs to completion.
  always_comb begin
    state_next  = state_reg;
    poll_next   = poll_reg;
    lat_next    = lat_reg;
    sample_next = sample_reg;
    avm_read    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!enable) begin
          poll_next = '0;
        end else if (poll_reg == POLL_LAST) begin
          poll_next  = '0;
          state_next = REQ;
        end else begin
          poll_next = poll_reg + 1'b1;
        end
      end
      REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          lat_next   = LAT_LAST;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_reg == '0) begin
          sample_next = avm_readdata[DATA_WIDTH-1:0];
          state_next  = CAPTURE;
        end else begin
          lat_next = lat_reg - 1'b1;
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  qbert_switch_debounce #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample_reg),
    .sample_valid(state_reg == CAPTURE),
    .sw_value    (sw_value),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .sw_changed  (sw_changed)
  );

endmodule

// File: tb/tb_qbert_switch_poller.sv
// Directed bench for qbert_switch_poller with POLL_PERIOD=8, READ_LATENCY=1,
// STABLE_COUNT=3, DATA_WIDTH=4.
module tb_qbert_switch_poller;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [3:0]  sw_value, sw_rise, sw_fall;
  logic        sw_changed;
  logic [3:0]  slave_val;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prev_read_cyc = 0;

  // Upper bits are always set so any leakage into the switch word shows up.
  assign avm_readdata = {28'hFFF_FFFF, slave_val};

  qbert_switch_poller #(
    .DATA_WIDTH  (4),
    .POLL_PERIOD (8),
    .READ_LATENCY(1),
    .SLAVE_ADDR  (0),
    .STABLE_COUNT(3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .sw_value       (sw_value),
    .sw_rise        (sw_rise),
    .sw_fall        (sw_fall),
    .sw_changed     (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] val;
    logic [3:0] exp_v;
    logic [3:0] exp_r;
    logic [3:0] exp_f;
    logic       exp_c;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Counts rising edges until avm_read is seen high at a falling edge.
  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!avm_read && n < 100);
    if (!avm_read) check("read_timeout", {31'd0, avm_read}, 32'd1);
    prev_read_cyc = cyc;
  endtask

  // One zero-wait poll with slave value val, then check the debounce result.
  task automatic do_poll(input logic [3:0] val, input logic [3:0] ev, input logic [3:0] er,
                         input logic [3:0] ef, input logic ec, input int idx);
    int n;
    int last;
    last = prev_read_cyc;
    slave_val = val;
    wait_read(n);
    if (idx == 0) check("first_read_delay", n, 8);
    else if (idx > 0) check("poll_interval", prev_read_cyc - last, 11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sw_value", {28'd0, sw_value}, {28'd0, ev});
    check("sw_rise", {28'd0, sw_rise}, {28'd0, er});
    check("sw_fall", {28'd0, sw_fall}, {28'd0, ef});
    check("sw_changed", {31'd0, sw_changed}, {31'd0, ec});
    @(negedge clk);
    check("pulse_cleared", {23'd0, sw_changed, sw_rise, sw_fall}, 32'd0);
    $display("poll %0d: slave=%b sw_value=%b rise=%b fall=%b changed=%b",
             idx, val, sw_value, er, ef, ec);
  endtask

  // Poll with waitrequest held for `stall` cycles; readdata carries `good`
  // only during the single cycle in which the sample must be taken.
  task automatic stalled_poll(input logic [3:0] good, input logic [3:0] junk, input int stall);
    int n;
    avm_waitrequest = 1'b1;
    slave_val = junk;
    wait_read(n);
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_read_held", {31'd0, avm_read}, 32'd1);
      check("stall_addr", {30'd0, avm_address}, 32'd0);
    end
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1 slave_val = good;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    check("read_dropped_after_accept", {31'd0, avm_read}, 32'd0);
    @(posedge clk);
    #1 slave_val = junk;
    $display("stalled poll: stall=%0d good=%b", stall, good);
  endtask

  initial begin
    int n;
    int hits;
    vecs[0] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0101, 4'b0000, 1'b1};
    vecs[3] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    vecs[5] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{4'b0011, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    vecs[7] = '{4'b0011, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    vecs[8] = '{4'b0011, 4'b0011, 4'b0010, 4'b0100, 1'b1};
    vecs[9] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0};

    reset_n = 1'b0;
    enable = 1'b0;
    avm_waitrequest = 1'b0;
    slave_val = 4'b0101;
    #12;
    check("reset_read", {31'd0, avm_read}, 32'd0);
    check("reset_addr", {30'd0, avm_address}, 32'd0);
    check("reset_outputs", {19'd0, sw_value, sw_rise, sw_fall, sw_changed}, 32'd0);
    $display("reset: read=%b sw_value=%b", avm_read, sw_value);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;

    // Constant value, glitch rejection and a genuine change.
    for (int i = 0; i < 10; i++)
      do_poll(vecs[i].val, vecs[i].exp_v, vecs[i].exp_r, vecs[i].exp_f, vecs[i].exp_c, i);

    // Stalled reads; the new value only reaches sw_value if every sample is exact.
    stalled_poll(4'b1010, 4'b0011, 5);
    stalled_poll(4'b1010, 4'b0011, 1);
    stalled_poll(4'b1010, 4'b0011, 3);
    @(negedge clk);
    check("no_early_update", {28'd0, sw_value}, 32'h3);
    @(negedge clk);
    check("stall_sw_value", {28'd0, sw_value}, 32'ha);
    check("stall_rise", {28'd0, sw_rise}, 32'h8);
    check("stall_fall", {28'd0, sw_fall}, 32'h1);
    check("stall_changed", {31'd0, sw_changed}, 32'd1);
    @(negedge clk);
    check("stall_pulse_cleared", {31'd0, sw_changed}, 32'd0);
    avm_waitrequest = 1'b0;

    // Enable dropped during WAIT: the read still counts as the third sample.
    do_poll(4'b0110, 4'b1010, 4'b0000, 4'b0000, 1'b0, -1);
    do_poll(4'b0110, 4'b1010, 4'b0000, 4'b0000, 1'b0, -1);
    wait_read(n);
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("en_drop_sw_value", {28'd0, sw_value}, 32'h6);
    check("en_drop_rise", {28'd0, sw_rise}, 32'h4);
    check("en_drop_fall", {28'd0, sw_fall}, 32'h8);
    check("en_drop_changed", {31'd0, sw_changed}, 32'd1);
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (avm_read) hits++;
    end
    check("no_read_while_disabled", hits, 0);
    $display("enable low: reads seen=%0d", hits);
    avm_waitrequest = 1'b1;
    enable = 1'b1;
    wait_read(n);
    check("reenable_delay", n, 8);
    $display("re-enable: first read after %0d cycles", n);

    // Asynchronous reset while the read is stalled in REQ.
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_read", {31'd0, avm_read}, 32'd0);
    check("async_reset_sw_value", {28'd0, sw_value}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held_read", {31'd0, avm_read}, 32'd0);
    avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    wait_read(n);
    check("post_reset_delay", n, 8);
    $display("reset release: first read after %0d cycles", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
